proc_mem_responder: RTL

- Synthesizable memory responder: the memory side of the processor's memory port.
- Samples the processor's address, write data and write enable; returns read data on the processor's data-input bus after a fixed, parameterised latency.
- Used as the DUT-side memory in processor-level benches and as standalone memory for the memory agent.
- Includes a bench preload port, access counters and an address-error flag.

---
 rtl/proc_mem_responder.sv | 65 ++++++
 1 files changed

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: processor-side memory with fixed read latency, bench preload, saturating access counters and address-error flag
module proc_mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_memAddr,
  input  logic [DATA_W-1:0] i_memData,
  input  logic              i_memWrEnable,
  output logic [DATA_W-1:0] o_memData,
  input  logic              i_loadEn,
  input  logic [ADDR_W-1:0] i_loadAddr,
  input  logic [DATA_W-1:0] i_loadData,
  output logic              o_addrErr,
  output logic [15:0]       o_wrCount,
  output logic [15:0]       o_rdCount
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_lat_check
    $error("READ_LAT must be in 1..4");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_q [READ_LAT];
  logic [DATA_W-1:0] pipe_d [READ_LAT];
  logic              err_q, err_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              mem_ok, load_ok, wr_ok, rd_ok;
  logic [IW-1:0]     mem_idx, load_idx;
  always_comb begin
    mem_ok   = {1'b0, i_memAddr} < LIMIT;
    load_ok  = i_loadEn && ({1'b0, i_loadAddr} < LIMIT);
    mem_idx  = i_memAddr[IW-1:0];
    load_idx = i_loadAddr[IW-1:0];
    wr_ok    = i_memWrEnable && mem_ok && !(load_ok && i_loadAddr == i_memAddr);
    rd_ok    = !i_memWrEnable && mem_ok;
    pipe_d[0] = mem_ok ? mem[mem_idx] : '0;
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
    err_d    = !mem_ok;
    wr_cnt_d = wr_cnt_q + 16'(wr_ok && wr_cnt_q != 16'hFFFF);
    rd_cnt_d = rd_cnt_q + 16'(rd_ok && rd_cnt_q != 16'hFFFF);
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      pipe_q   <= pipe_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      if (load_ok) mem[load_idx] <= i_loadData;
      if (wr_ok) mem[mem_idx] <= i_memData;
    end
  end
  assign o_memData = pipe_q[READ_LAT-1];
  assign o_addrErr = err_q;
  assign o_wrCount = wr_cnt_q;
  assign o_rdCount = rd_cnt_q;
endmodule
